// File: rtl/exe_div_unit_pkg.sv
// Shared definitions for the EXE-stage restoring divider: FSM states and default sizes.
package exe_div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/exe_div_unit_div_abs_neg.sv
// Conditional two's-complement negate, used both for operand magnitudes and result sign fixup.
module div_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/exe_div_unit.sv
// Multi-cycle radix-2 restoring divider for the EXE stage (HI = remainder, LO = quotient).
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle instead of WIDTH.
module exe_div_unit
    import exe_div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_cancel,
    input  logic             result_ack,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo,
    output logic             div_done,
    output logic             div_busy,
    output logic             div_stall
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_raw_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             busy_q;

    logic             dvd_neg;
    logic             dvs_neg;
    logic             dvs_zero;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] hi_d;
    logic             last_iter;

    assign dvd_neg  = div_signed & dividend[WIDTH-1];
    assign dvs_neg  = div_signed & divisor[WIDTH-1];
    assign dvs_zero = (divisor == '0);

    div_abs_neg #(.W(WIDTH)) u_abs_dvd (.val_i(dividend), .neg_i(dvd_neg), .res_o(dvd_abs));
    div_abs_neg #(.W(WIDTH)) u_abs_dvs (.val_i(divisor),  .neg_i(dvs_neg), .res_o(dvs_abs));

    // quot_q starts holding the dividend magnitude and shifts quotient bits in from the right.
    // The restored remainder is always below the divisor, so WIDTH bits suffice between iterations.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign rem_d     = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_d    = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    div_abs_neg #(.W(WIDTH)) u_fix_q (.val_i(quot_d), .neg_i(q_neg_q), .res_o(q_fix));
    div_abs_neg #(.W(WIDTH)) u_fix_r (.val_i(rem_d),  .neg_i(r_neg_q), .res_o(r_fix));

    // Divide by zero reports all-ones quotient and the untouched dividend, regardless of sign.
    assign lo_d = dz_q ? '1 : q_fix;
    assign hi_d = dz_q ? dvd_raw_q : r_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            dvd_raw_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else if (div_cancel) begin
            state_q <= DIV_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_start) begin
                        dvd_raw_q <= dividend;
                        q_neg_q   <= dvd_neg ^ dvs_neg;
                        r_neg_q   <= dvd_neg;
                        dz_q      <= dvs_zero;
                        quot_q    <= dvd_abs;
                        rem_q     <= '0;
                        dvs_q     <= dvs_abs;
                        cnt_q     <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (dvs_zero) begin
                            state_q <= DIV_DONE;
                            lo_q    <= '1;
                            hi_q    <= dividend;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DIV_BUSY;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= DIV_BUSY;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                DIV_BUSY: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q <= DIV_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        lo_q    <= lo_d;
                        hi_q    <= hi_d;
                    end
                end
                DIV_DONE: begin
                    if (result_ack) begin
                        state_q <= DIV_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the accepting cycle already holds the pipeline; forced low while in reset.
    assign div_stall = rst_n & (((state_q == DIV_IDLE) & div_start & ~div_cancel)
                                | (state_q == DIV_BUSY));
    assign div_busy  = busy_q;
    assign div_done  = done_q;
    assign div_hi    = hi_q;
    assign div_lo    = lo_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: stimulus pushes expected {lo,hi}; a negedge monitor pops on each new div_done.
module tb_exe_div_unit;

`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 0;
`else
    localparam int DZ_LAT = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_cancel;
    logic        result_ack;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_done;
    logic        div_busy;
    logic        div_stall;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic        done_seen = 1'b0;

    exe_div_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_cancel (div_cancel),
        .result_ack (result_ack),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .div_done   (div_done),
        .div_busy   (div_busy),
        .div_stall  (div_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each freshly asserted result against the oldest expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (div_done && !done_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got lo=%h hi=%h expected no result", div_lo, div_hi);
            end else begin
                e = exp_q.pop_front();
                $display("result lo=%h hi=%h (expected lo=%h hi=%h)", div_lo, div_hi, e[63:32], e[31:0]);
                check("sb_lo", div_lo, e[63:32]);
                check("sb_hi", div_hi, e[31:0]);
            end
        end
        done_seen = div_done;
    end

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [31:0] elo, input logic [31:0] ehi,
                          input int exp_lat, input bit hold);
        int lat;
        int busy_n;
        int bad;
        @(posedge clk); #1;
        dividend   = a;
        divisor    = b;
        div_signed = sg;
        div_start  = 1'b1;
        result_ack = !hold;
        exp_q.push_back({elo, ehi});
        #1 check({tag, "_stall_accept"}, {31'd0, div_stall}, 32'd1);
        @(posedge clk); #1;
        div_start  = 1'b0;
        dividend   = ~a;
        divisor    = ~b;
        div_signed = ~sg;
        lat = 0;
        busy_n = 0;
        bad = 0;
        while (!div_done && lat < 100) begin
            if (div_busy) busy_n++;
            if (div_stall !== div_busy) bad++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_n, exp_lat);
        check({tag, "_stall_eq_busy"}, bad, 0);
        check({tag, "_stall_in_done"}, {31'd0, div_stall}, 32'd0);
        if (!hold) begin
            @(posedge clk); #1;
            check({tag, "_done_one_cycle"}, {31'd0, div_done}, 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        div_cancel = 1'b0;
        result_ack = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_lo",    div_lo, 32'd0);
        check("rst_hi",    div_hi, 32'd0);
        check("rst_done",  {31'd0, div_done},  32'd0);
        check("rst_busy",  {31'd0, div_busy},  32'd0);
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          32, 1'b0);
        run_op("s-7_2",    32'hFFFFFFF9,   32'h2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   32, 1'b0);
        run_op("s7_-2",    32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          32, 1'b0);
        run_op("s_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          32, 1'b0);
        run_op("u_dz",     32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   DZ_LAT, 1'b0);
        run_op("s_dz",     32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   DZ_LAT, 1'b0);

        // Cancel together with start must not accept.
        @(posedge clk); #1;
        dividend = 32'd50; divisor = 32'd5; div_signed = 1'b0;
        div_start = 1'b1; div_cancel = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0; div_cancel = 1'b0;
        check("cancel_wins_busy", {31'd0, div_busy}, 32'd0);

        // Cancel at BUSY cycle 10; no result may appear.
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("cancel_pre_busy", {31'd0, div_busy}, 32'd1);
        div_cancel = 1'b1;
        @(posedge clk); #1;
        div_cancel = 1'b0;
        check("cancel_busy",  {31'd0, div_busy},  32'd0);
        check("cancel_stall", {31'd0, div_stall}, 32'd0);
        check("cancel_done",  {31'd0, div_done},  32'd0);
        run_op("after_cancel", 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 32, 1'b0);

        // Hold ack low for 5 cycles; a start during DONE must be ignored.
        run_op("hold", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 32, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_done", {31'd0, div_done}, 32'd1);
            check("hold_lo",   div_lo, 32'd30);
            check("hold_hi",   div_hi, 32'd10);
            check("hold_busy", {31'd0, div_busy}, 32'd0);
            if (i == 1) begin
                dividend = 32'd5; divisor = 32'd1; div_signed = 1'b0; div_start = 1'b1;
            end
            if (i == 3) div_start = 1'b0;
            @(posedge clk); #1;
        end
        result_ack = 1'b1;
        @(posedge clk); #1;
        check("ack_done", {31'd0, div_done}, 32'd0);
        check("ack_busy", {31'd0, div_busy}, 32'd0);
        check("ack_lo_kept", div_lo, 32'd30);

        // Asynchronous reset in the middle of an operation.
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        div_start = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_lo",    div_lo, 32'd0);
        check("mid_rst_hi",    div_hi, 32'd0);
        check("mid_rst_done",  {31'd0, div_done},  32'd0);
        check("mid_rst_busy",  {31'd0, div_busy},  32'd0);
        check("mid_rst_stall", {31'd0, div_stall}, 32'd0);
        @(negedge clk);
        div_start = 1'b0;
        rst_n = 1'b1;
        run_op("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 32, 1'b0);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
